// File: rtl/pwr_meas_sequencer_if.sv
// AXI4-Lite master-side bundle for the power-measurement sequencer.
// PROT and WSTRB are omitted; the interconnect supplies their defaults.
interface pwr_meas_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/pwr_meas_sequencer.sv
// Hardware-triggered measurement: write CONFIG and CONTROL, poll STATUS until done,
// then read RESULT. Reports the result or an error code to the requester.
module pwr_meas_sequencer #(
  parameter int unsigned                   C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned                   C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = '0,
  parameter int unsigned                   POLL_GAP           = 16,
  parameter int unsigned                   TIMEOUT_POLLS      = 1024
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic                          start,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] sample_count,
  output logic                          busy,
  output logic [C_M_AXI_DATA_WIDTH-1:0] result,
  output logic                          result_valid,
  output logic [1:0]                    error,
  pwr_meas_sequencer_if.master          m_axi
);

  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] AddrCfg  = BASE_ADDR;
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] AddrCtl  = BASE_ADDR + C_M_AXI_ADDR_WIDTH'(4);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] AddrStat = BASE_ADDR + C_M_AXI_ADDR_WIDTH'(8);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] AddrRes  = BASE_ADDR + C_M_AXI_ADDR_WIDTH'(12);

  localparam logic [1:0] ErrNone    = 2'b00;
  localparam logic [1:0] ErrResp    = 2'b01;
  localparam logic [1:0] ErrTimeout = 2'b10;

  typedef enum logic [2:0] {StIdle, StWrCfg, StWrCtl, StRdStat, StGap, StRdRes} state_e;

  state_e                          state_q, state_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   cfg_q, cfg_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   result_q, result_d;
  logic                            result_valid_q, result_valid_d;
  logic [1:0]                      error_q, error_d;
  logic [31:0]                     poll_cnt_q, poll_cnt_d;
  logic [31:0]                     gap_cnt_q, gap_cnt_d;
  // Per-channel "already handshaken" flags so each VALID drops on its own handshake.
  logic                            aw_done_q, aw_done_d;
  logic                            w_done_q, w_done_d;
  logic                            ar_done_q, ar_done_d;

  logic                            aw_valid, w_valid, ar_valid, b_ready, r_ready;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   aw_addr, ar_addr;
  logic [C_M_AXI_DATA_WIDTH-1:0]   w_data;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q        <= StIdle;
      cfg_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      error_q        <= ErrNone;
      poll_cnt_q     <= '0;
      gap_cnt_q      <= '0;
      aw_done_q      <= 1'b0;
      w_done_q       <= 1'b0;
      ar_done_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cfg_q          <= cfg_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      error_q        <= error_d;
      poll_cnt_q     <= poll_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      aw_done_q      <= aw_done_d;
      w_done_q       <= w_done_d;
      ar_done_q      <= ar_done_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cfg_d          = cfg_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    error_d        = error_q;
    poll_cnt_d     = poll_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    aw_done_d      = aw_done_q;
    w_done_d       = w_done_q;
    ar_done_d      = ar_done_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cfg_d      = sample_count;
          error_d    = ErrNone;
          poll_cnt_d = '0;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          ar_done_d  = 1'b0;
          state_d    = StWrCfg;
        end
      end
      StWrCfg, StWrCtl: begin
        if (aw_valid && m_axi.awready) aw_done_d = 1'b1;
        if (w_valid && m_axi.wready)   w_done_d  = 1'b1;
        if (m_axi.bvalid) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (m_axi.bresp != 2'b00) begin
            error_d = ErrResp;
            state_d = StIdle;
          end else begin
            state_d = (state_q == StWrCfg) ? StWrCtl : StRdStat;
          end
        end
      end
      StRdStat: begin
        if (ar_valid && m_axi.arready) ar_done_d = 1'b1;
        if (m_axi.rvalid) begin
          ar_done_d = 1'b0;
          if (m_axi.rresp != 2'b00) begin
            error_d = ErrResp;
            state_d = StIdle;
          end else if (m_axi.rdata[0]) begin
            state_d = StRdRes;
          end else begin
            poll_cnt_d = poll_cnt_q + 32'd1;
            gap_cnt_d  = '0;
            if (poll_cnt_d == 32'(TIMEOUT_POLLS)) begin
              error_d = ErrTimeout;
              state_d = StIdle;
            end else begin
              state_d = StGap;
            end
          end
        end
      end
      StGap: begin
        if (gap_cnt_q == 32'(POLL_GAP) - 32'd1) state_d = StRdStat;
        else                                    gap_cnt_d = gap_cnt_q + 32'd1;
      end
      StRdRes: begin
        if (ar_valid && m_axi.arready) ar_done_d = 1'b1;
        if (m_axi.rvalid) begin
          ar_done_d = 1'b0;
          state_d   = StIdle;
          if (m_axi.rresp != 2'b00) begin
            error_d = ErrResp;
          end else begin
            result_d       = m_axi.rdata;
            result_valid_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    ar_valid = 1'b0;
    b_ready  = 1'b0;
    r_ready  = 1'b0;
    aw_addr  = '0;
    ar_addr  = '0;
    w_data   = '0;
    unique case (state_q)
      StWrCfg: begin
        aw_valid = !aw_done_q;
        w_valid  = !w_done_q;
        b_ready  = 1'b1;
        aw_addr  = AddrCfg;
        w_data   = cfg_q;
      end
      StWrCtl: begin
        aw_valid = !aw_done_q;
        w_valid  = !w_done_q;
        b_ready  = 1'b1;
        aw_addr  = AddrCtl;
        w_data   = C_M_AXI_DATA_WIDTH'(1);
      end
      StRdStat: begin
        ar_valid = !ar_done_q;
        r_ready  = 1'b1;
        ar_addr  = AddrStat;
      end
      StRdRes: begin
        ar_valid = !ar_done_q;
        r_ready  = 1'b1;
        ar_addr  = AddrRes;
      end
      default: ;
    endcase
  end

  assign m_axi.awvalid = aw_valid;
  assign m_axi.awaddr  = aw_addr;
  assign m_axi.wvalid  = w_valid;
  assign m_axi.wdata   = w_data;
  assign m_axi.bready  = b_ready;
  assign m_axi.arvalid = ar_valid;
  assign m_axi.araddr  = ar_addr;
  assign m_axi.rready  = r_ready;

  assign busy         = (state_q != StIdle);
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign error        = error_q;

endmodule

// File: tb/tb_pwr_meas_sequencer.sv
// Bench for pwr_meas_sequencer: table of runs against a configurable AXI4-Lite slave,
// with an expected-transaction queue checked as the bus handshakes occur.
module tb_pwr_meas_sequencer;
  localparam int unsigned PollGap      = 16;
  localparam int unsigned TimeoutPolls = 4;

  logic        tb_ACLK = 1'b0;
  logic        tb_ARESET = 1'b1;
  logic        start = 1'b0;
  logic [31:0] sample_count = '0;
  logic        busy;
  logic [31:0] result;
  logic        result_valid;
  logic [1:0]  error;

  int checks = 0;
  int failures = 0;

  pwr_meas_sequencer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  pwr_meas_sequencer #(
    .C_M_AXI_ADDR_WIDTH(32),
    .C_M_AXI_DATA_WIDTH(32),
    .BASE_ADDR         (32'h0),
    .POLL_GAP          (PollGap),
    .TIMEOUT_POLLS     (TimeoutPolls)
  ) dut (
    .ACLK        (tb_ACLK),
    .ARESET      (tb_ARESET),
    .start       (start),
    .sample_count(sample_count),
    .busy        (busy),
    .result      (result),
    .result_valid(result_valid),
    .error       (error),
    .m_axi       (axi)
  );

  always #5 tb_ACLK = ~tb_ACLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Slave model configuration
  int          aw_lat = 0;
  int          done_at = 1;
  int          stat_base = 0;
  logic [31:0] res_data = '0;
  logic [1:0]  ctl_bresp = 2'b00;
  logic [1:0]  res_rresp = 2'b00;

  int          aw_wait;
  int          stat_reads;
  logic        got_aw, got_w;
  logic [31:0] s_awaddr;
  wire  [31:0] cur_awaddr = got_aw ? s_awaddr : axi.awaddr;
  wire         aw_hs = axi.awvalid && axi.awready;
  wire         w_hs  = axi.wvalid && axi.wready;

  assign axi.awready = (aw_wait >= aw_lat);
  assign axi.wready  = 1'b1;
  assign axi.arready = 1'b1;

  always @(posedge tb_ACLK or posedge tb_ARESET) begin
    if (tb_ARESET) begin
      aw_wait    <= 0;
      stat_reads <= 0;
      got_aw     <= 1'b0;
      got_w      <= 1'b0;
      s_awaddr   <= '0;
      axi.bvalid <= 1'b0;
      axi.bresp  <= 2'b00;
      axi.rvalid <= 1'b0;
      axi.rresp  <= 2'b00;
      axi.rdata  <= '0;
    end else begin
      if (axi.awvalid && !axi.awready) aw_wait <= aw_wait + 1;
      else                             aw_wait <= 0;
      if (aw_hs) begin
        got_aw   <= 1'b1;
        s_awaddr <= axi.awaddr;
      end
      if (w_hs) got_w <= 1'b1;
      if (axi.bvalid && axi.bready) begin
        axi.bvalid <= 1'b0;
      end else if (!axi.bvalid && (got_aw || aw_hs) && (got_w || w_hs)) begin
        axi.bvalid <= 1'b1;
        axi.bresp  <= (cur_awaddr == 32'h4) ? ctl_bresp : 2'b00;
        got_aw     <= 1'b0;
        got_w      <= 1'b0;
      end
      if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
      if (axi.arvalid && axi.arready) begin
        axi.rvalid <= 1'b1;
        if (axi.araddr == 32'h8) begin
          stat_reads <= stat_reads + 1;
          axi.rdata  <= ((stat_reads + 1 - stat_base) == done_at) ? 32'h1 : 32'h2;
          axi.rresp  <= 2'b00;
        end else begin
          axi.rdata  <= res_data;
          axi.rresp  <= res_rresp;
        end
      end
    end
  end

  // Scoreboard of bus transactions, compared when each handshake is seen
  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  int          ar_cyc_q[$];
  int          ncyc = 0;
  logic        m_got_aw = 1'b0, m_got_w = 1'b0;
  logic [31:0] m_addr = '0, m_data = '0;

  task automatic compare_txn(input txn_t act);
    txn_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_txn", {31'd0, act.wr, act.addr}, 64'hFFFF_FFFF_FFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      check(act.wr ? "write_txn" : "read_txn", {act.addr, act.data}, {e.addr, e.data});
    end
  endtask

  always @(negedge tb_ACLK) begin
    ncyc++;
    if (tb_ARESET) begin
      m_got_aw = 1'b0;
      m_got_w  = 1'b0;
    end else begin
      if (axi.awvalid && axi.awready) begin
        m_got_aw = 1'b1;
        m_addr   = axi.awaddr;
      end
      if (axi.wvalid && axi.wready) begin
        m_got_w = 1'b1;
        m_data  = axi.wdata;
      end
      if (m_got_aw && m_got_w) begin
        compare_txn({1'b1, m_addr, m_data});
        m_got_aw = 1'b0;
        m_got_w  = 1'b0;
      end
      if (axi.arvalid && axi.arready) begin
        if (axi.araddr == 32'h8) ar_cyc_q.push_back(ncyc);
        compare_txn({1'b0, axi.araddr, 32'h0});
      end
    end
  end

  typedef struct {
    logic [31:0] sc;
    int          done_at;
    logic [31:0] res;
    logic [1:0]  ctl_bresp;
    logic [1:0]  res_rresp;
    int          aw_lat;
    int          restart_cyc;
    logic [31:0] exp_result;
    logic [1:0]  exp_error;
    int          exp_rv_cyc;
    int          exp_done_cyc;
    int          exp_stat_reads;
    int          exp_aw_cyc;
    int          exp_w_cyc;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v, input string tag);
    int c, rv_cyc, done_cyc, rv_cnt, aw_cnt, w_cnt;
    aw_lat    = v.aw_lat;
    done_at   = v.done_at;
    res_data  = v.res;
    ctl_bresp = v.ctl_bresp;
    res_rresp = v.res_rresp;
    ar_cyc_q.delete();
    stat_base = stat_reads;
    exp_q.push_back({1'b1, 32'h0, v.sc});
    exp_q.push_back({1'b1, 32'h4, 32'h1});
    for (int i = 0; i < v.exp_stat_reads; i++) exp_q.push_back({1'b0, 32'h8, 32'h0});
    if (v.done_at != 0 && v.ctl_bresp == 2'b00) exp_q.push_back({1'b0, 32'hC, 32'h0});

    @(negedge tb_ACLK);
    start        = 1'b1;
    sample_count = v.sc;
    c = 0; rv_cyc = 0; done_cyc = 0; rv_cnt = 0; aw_cnt = 0; w_cnt = 0;
    while (done_cyc == 0 && c < 200) begin
      @(negedge tb_ACLK);
      c++;
      start = (c == v.restart_cyc);
      if (start) sample_count = 32'hDEAD_0000;
      if (axi.awvalid) aw_cnt++;
      if (axi.wvalid) w_cnt++;
      if (result_valid) begin
        rv_cnt++;
        if (rv_cyc == 0) rv_cyc = c;
      end
      if (!busy) done_cyc = c;
    end
    start = 1'b0;
    repeat (3) begin
      @(negedge tb_ACLK);
      if (result_valid) rv_cnt++;
    end

    check({tag, " busy_fall_cycle"}, 64'(done_cyc), 64'(v.exp_done_cyc));
    check({tag, " result_valid_cycle"}, 64'(rv_cyc), 64'(v.exp_rv_cyc));
    check({tag, " result_valid_pulses"}, 64'(rv_cnt), (v.exp_rv_cyc != 0) ? 64'd1 : 64'd0);
    check({tag, " result"}, 64'(result), 64'(v.exp_result));
    check({tag, " error"}, 64'(error), 64'(v.exp_error));
    check({tag, " awvalid_cycles"}, 64'(aw_cnt), 64'(v.exp_aw_cyc));
    check({tag, " wvalid_cycles"}, 64'(w_cnt), 64'(v.exp_w_cyc));
    check({tag, " status_reads"}, 64'(stat_reads - stat_base), 64'(v.exp_stat_reads));
    check({tag, " txns_outstanding"}, 64'(exp_q.size()), 64'd0);
    for (int i = 1; i < ar_cyc_q.size(); i++)
      check({tag, " poll_spacing"}, 64'(ar_cyc_q[i] - ar_cyc_q[i-1]), 64'(PollGap + 2));
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " result"}, 64'(result), 64'd0);
    check({tag, " result_valid"}, 64'(result_valid), 64'd0);
    check({tag, " error"}, 64'(error), 64'd0);
    check({tag, " valids"}, {60'd0, axi.awvalid, axi.wvalid, axi.arvalid, 1'b0}, 64'd0);
    check({tag, " readys"}, {62'd0, axi.bready, axi.rready}, 64'd0);
    check({tag, " addr_data"}, {axi.awaddr | axi.araddr, axi.wdata}, 64'd0);
  endtask

  initial begin
    //          sc            done res           ctl    rres   awl rst  exp_result     err    rv  fall polls aw w
    vecs[0] = '{32'h0000_1000, 1, 32'hBEEF_0011, 2'b00, 2'b00, 0, 0, 32'hBEEF_0011, 2'b00, 9,  9,  1, 2, 2};
    vecs[1] = '{32'h0000_2222, 3, 32'h1234_5678, 2'b00, 2'b00, 0, 0, 32'h1234_5678, 2'b00, 45, 45, 3, 2, 2};
    vecs[2] = '{32'h0000_3333, 1, 32'hAAAA_5555, 2'b10, 2'b00, 0, 0, 32'h1234_5678, 2'b01, 0,  5,  0, 2, 2};
    vecs[3] = '{32'h0000_4444, 0, 32'h5555_AAAA, 2'b00, 2'b00, 0, 0, 32'h1234_5678, 2'b10, 0,  61, 4, 2, 2};
    vecs[4] = '{32'h0000_5555, 1, 32'hCAFE_0001, 2'b00, 2'b00, 3, 3, 32'hCAFE_0001, 2'b00, 15, 15, 1, 8, 2};
    vecs[5] = '{32'h0000_6666, 1, 32'h0BAD_0BAD, 2'b00, 2'b10, 0, 0, 32'hCAFE_0001, 2'b01, 0,  9,  1, 2, 2};
    vecs[6] = '{32'h0000_7777, 1, 32'h7777_7777, 2'b01, 2'b00, 0, 0, 32'hCAFE_0001, 2'b01, 0,  5,  0, 2, 2};

    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge tb_ACLK);
    tb_ARESET = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset asserted mid-GAP after the second STATUS poll.
    aw_lat = 0; done_at = 0; ctl_bresp = 2'b00; res_rresp = 2'b00;
    stat_base = stat_reads;
    exp_q.push_back({1'b1, 32'h0, 32'h0000_8888});
    exp_q.push_back({1'b1, 32'h4, 32'h1});
    exp_q.push_back({1'b0, 32'h8, 32'h0});
    exp_q.push_back({1'b0, 32'h8, 32'h0});
    @(negedge tb_ACLK);
    start = 1'b1;
    sample_count = 32'h0000_8888;
    @(negedge tb_ACLK);
    start = 1'b0;
    repeat (29) @(negedge tb_ACLK);
    check("gap busy", 64'(busy), 64'd1);
    check("gap status_reads", 64'(stat_reads - stat_base), 64'd2);
    tb_ARESET = 1'b1;
    #1;
    check_reset_outputs("midreset");
    check("midreset txns_outstanding", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(negedge tb_ACLK);
    tb_ARESET = 1'b0;
    run_vec('{32'h0000_9999, 1, 32'h0F0F_0F0F, 2'b00, 2'b00, 0, 0, 32'h0F0F_0F0F, 2'b00,
              9, 9, 1, 2, 2}, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
